// File: rtl/isa_vector_intc_if.sv
// ISA-side signal bundle for the vectored interrupt controller.
// Strobes are active low; the master drives the host side and the slave is the controller.
interface isa_vector_intc_if #(
  parameter int NUM_IRQ = 8
) ();
  logic [NUM_IRQ-1:0] irq;
  logic [9:0]         addr;
  logic [7:0]         d_in;
  logic               iow_n;
  logic               ior_n;
  logic               dack_n;
  logic               intr;
  logic [7:0]         dout;
  logic               dout_en;

  modport master (
    output irq, addr, d_in, iow_n, ior_n, dack_n,
    input  intr, dout, dout_en
  );

  modport slave (
    input  irq, addr, d_in, iow_n, ior_n, dack_n,
    output intr, dout, dout_en
  );
endinterface

// File: rtl/isa_vector_intc.sv
// Vectored interrupt controller: edge-latched requests, mask, fixed priority and
// in-service tracking, INTA vector delivery and I/O-mapped control registers.
module isa_vector_intc #(
  parameter int         NUM_IRQ      = 8,
  parameter logic [9:0] BASE_PORT    = 10'h020,
  parameter logic [7:0] VECTOR_BASE  = 8'h08,
  parameter logic [7:0] SPURIOUS_VEC = 8'h0F,
  parameter bit         AUTO_EOI     = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  isa_vector_intc_if.slave    isa_io
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_e;

  localparam logic [NUM_IRQ-1:0] ONE   = NUM_IRQ'(1'b1);
  localparam logic [9:0]         PORT1 = BASE_PORT + 10'd1;
  localparam logic [9:0]         PORT2 = BASE_PORT + 10'd2;

  function automatic logic [NUM_IRQ-1:0] lowest_1h(input logic [NUM_IRQ-1:0] v);
    lowest_1h = v & (~v + ONE);
  endfunction

  function automatic logic [7:0] onehot_idx(input logic [NUM_IRQ-1:0] oh);
    onehot_idx = 8'd0;
    for (int i = 0; i < NUM_IRQ; i++) onehot_idx = oh[i] ? 8'(i) : onehot_idx;
  endfunction

  // A channel is blocked by any in-service bit at its own or a higher priority.
  function automatic logic [NUM_IRQ-1:0] eligible(input logic [NUM_IRQ-1:0] pend,
                                                 input logic [NUM_IRQ-1:0] mask,
                                                 input logic [NUM_IRQ-1:0] isr);
    logic blk;
    blk = 1'b0;
    eligible = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blk         = blk | isr[i];
      eligible[i] = pend[i] & ~mask[i] & ~blk;
    end
  endfunction

  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q, irq_h_q;
  logic [2:0]         strb_s1_q, strb_s2_q, strb_h_q;
  logic [2:0]         strb_act_s;
  logic [NUM_IRQ-1:0] mask_q, mask_d, pend_q, pend_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0] mask_wr_s, pend_wr_s, isr_wr_s, irq_rise_s, wr_data_s, pick_s;
  logic               iow_end_s, ior_start_s, ior_end_s, dack_start_s, dack_end_s;
  logic               int_q, int_d, dout_en_q, dout_en_d;
  logic [7:0]         dout_q, dout_d;
  state_e             state_q, state_d;

  // Strobes are inverted to active-high so a cleared synchroniser means "not asserted".
  assign strb_act_s = {~isa_io.dack_n, ~isa_io.ior_n, ~isa_io.iow_n};

  // Two-flop synchronisers followed by the edge-history flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_s1_q  <= '0;
      irq_s2_q  <= '0;
      irq_h_q   <= '0;
      strb_s1_q <= 3'b000;
      strb_s2_q <= 3'b000;
      strb_h_q  <= 3'b000;
    end else begin
      irq_s1_q  <= isa_io.irq;
      irq_s2_q  <= irq_s1_q;
      irq_h_q   <= irq_s2_q;
      strb_s1_q <= strb_act_s;
      strb_s2_q <= strb_s1_q;
      strb_h_q  <= strb_s2_q;
    end
  end

  assign irq_rise_s   = irq_s2_q & ~irq_h_q;
  assign iow_end_s    = strb_h_q[0] & ~strb_s2_q[0];
  assign ior_start_s  = strb_s2_q[1] & ~strb_h_q[1];
  assign ior_end_s    = strb_h_q[1] & ~strb_s2_q[1];
  assign dack_start_s = strb_s2_q[2] & ~strb_h_q[2];
  assign dack_end_s   = strb_h_q[2] & ~strb_s2_q[2];
  assign wr_data_s    = isa_io.d_in[NUM_IRQ-1:0];

  // Register writes land first so a same-cycle ack sees their effect.
  always_comb begin
    mask_wr_s = mask_q;
    pend_wr_s = pend_q;
    isr_wr_s  = isr_q;
    if (iow_end_s) begin
      if (isa_io.addr == BASE_PORT)  mask_wr_s = wr_data_s;
      else if (isa_io.addr == PORT1) isr_wr_s  = isr_q & ~lowest_1h(isr_q);
      else if (isa_io.addr == PORT2) pend_wr_s = pend_q & ~wr_data_s;
      else                           mask_wr_s = mask_q;
    end else begin
      mask_wr_s = mask_q;
    end
  end

  assign pick_s = lowest_1h(eligible(pend_wr_s, mask_wr_s, isr_wr_s));

  // Ack state machine, read-back mux and next-state of the control registers.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_wr_s;
    pend_d    = pend_wr_s;
    isr_d     = isr_wr_s;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    int_d     = (|eligible(pend_q, mask_q, isr_q)) && (state_q == ST_IDLE);
    if (ior_start_s) begin
      if (isa_io.addr == BASE_PORT) begin
        dout_d    = 8'(mask_q);
        dout_en_d = 1'b1;
      end else if (isa_io.addr == PORT1) begin
        dout_d    = 8'(pend_q);
        dout_en_d = 1'b1;
      end else if (isa_io.addr == PORT2) begin
        dout_d    = 8'(isr_q);
        dout_en_d = 1'b1;
      end else begin
        dout_en_d = dout_en_q;
      end
    end else if (ior_end_s) begin
      dout_en_d = 1'b0;
    end else begin
      dout_en_d = dout_en_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (dack_start_s) begin
          state_d   = ST_ACK;
          dout_en_d = 1'b1;
          int_d     = 1'b0;
          if (|pick_s) begin
            dout_d = VECTOR_BASE + onehot_idx(pick_s);
            pend_d = pend_wr_s & ~pick_s;
            isr_d  = AUTO_EOI ? isr_wr_s : (isr_wr_s | pick_s);
          end else begin
            dout_d = SPURIOUS_VEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (dack_end_s) begin
          dout_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh edge wins over a same-cycle ack or software clear.
    pend_d = pend_d | irq_rise_s;
  end

  // State, control registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      int_q     <= 1'b0;
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      int_q     <= int_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign isa_io.intr    = int_q;
  assign isa_io.dout    = dout_q;
  assign isa_io.dout_en = dout_en_q;

endmodule

// File: tb/tb_isa_vector_intc.sv
// Directed bench for isa_vector_intc: one default instance and one AUTO_EOI instance
// share the same stimulus; expected values are hand-computed constants.
module tb_isa_vector_intc;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] rd_m, rd_a;

  isa_vector_intc_if #(.NUM_IRQ(8)) bus ();
  isa_vector_intc_if #(.NUM_IRQ(8)) bus_ae ();

  assign bus_ae.irq    = bus.irq;
  assign bus_ae.addr   = bus.addr;
  assign bus_ae.d_in   = bus.d_in;
  assign bus_ae.iow_n  = bus.iow_n;
  assign bus_ae.ior_n  = bus.ior_n;
  assign bus_ae.dack_n = bus.dack_n;

  isa_vector_intc #(.NUM_IRQ(8), .AUTO_EOI(1'b0)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .isa_io(bus)
  );

  isa_vector_intc #(.NUM_IRQ(8), .AUTO_EOI(1'b1)) u_dut_ae (
    .clk_i (clk),
    .rst_ni(rst_n),
    .isa_io(bus_ae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [9:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.d_in  = d;
    bus.iow_n = 1'b0;
    tick(4);
    bus.iow_n = 1'b1;
    tick(4);
  endtask

  task automatic io_read(input logic [9:0] a, output logic [7:0] dm, output logic [7:0] da);
    bus.addr  = a;
    bus.ior_n = 1'b0;
    tick(4);
    dm = bus.dout;
    da = bus_ae.dout;
    bus.ior_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    bus.irq = bus.irq | m;
    tick(3);
    bus.irq = bus.irq & ~m;
    tick(3);
  endtask

  task automatic dack_set(input logic v);
    bus.dack_n = v;
    tick(4);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.irq    = 8'h00;
    bus.addr   = 10'h000;
    bus.d_in   = 8'h00;
    bus.iow_n  = 1'b1;
    bus.ior_n  = 1'b1;
    bus.dack_n = 1'b1;
    tick(3);
    check_val("rst_int", {7'd0, bus.intr}, 8'h00);
    check_val("rst_douten", {7'd0, bus.dout_en}, 8'h00);
    check_val("rst_dout", bus.dout, 8'h00);
    rst_n = 1'b1;
    tick(2);
    io_read(10'h020, rd_m, rd_a);
    check_val("rst_mask", rd_m, 8'h00);

    // INT latency: low after 3 edges, high after the 4th
    bus.irq = 8'h08;
    tick(3);
    check_val("lat_int_early", {7'd0, bus.intr}, 8'h00);
    tick(1);
    check_val("lat_int_on", {7'd0, bus.intr}, 8'h01);
    bus.irq = 8'h00;
    tick(2);
    dack_set(1'b0);
    check_val("ack3_vec", bus.dout, 8'h0B);
    check_val("ack3_en", {7'd0, bus.dout_en}, 8'h01);
    check_val("ack3_int", {7'd0, bus.intr}, 8'h00);
    dack_set(1'b1);
    check_val("ack3_en_off", {7'd0, bus.dout_en}, 8'h00);
    io_read(10'h022, rd_m, rd_a);
    check_val("isr_after3", rd_m, 8'h08);
    io_write(10'h021, 8'h00);

    // Priority and in-service blocking
    pulse_irq(8'h22);
    check_val("p15_int", {7'd0, bus.intr}, 8'h01);
    dack_set(1'b0);
    check_val("p15_vec1", bus.dout, 8'h09);
    dack_set(1'b1);
    check_val("p15_blocked", {7'd0, bus.intr}, 8'h00);
    io_write(10'h021, 8'h00);
    check_val("p15_eoi_int", {7'd0, bus.intr}, 8'h01);
    dack_set(1'b0);
    check_val("p15_vec2", bus.dout, 8'h0D);
    dack_set(1'b1);
    io_write(10'h021, 8'h00);
    io_read(10'h022, rd_m, rd_a);
    check_val("p15_isr_clr", rd_m, 8'h00);

    // Masked channel still latches pending
    io_write(10'h020, 8'h04);
    pulse_irq(8'h04);
    check_val("mask_int", {7'd0, bus.intr}, 8'h00);
    io_read(10'h021, rd_m, rd_a);
    check_val("mask_pend", rd_m, 8'h04);
    io_write(10'h020, 8'h00);
    check_val("unmask_int", {7'd0, bus.intr}, 8'h01);
    dack_set(1'b0);
    check_val("unmask_vec", bus.dout, 8'h0A);
    dack_set(1'b1);
    io_write(10'h021, 8'h00);

    // Spurious ack leaves state alone; then software clear of pending
    io_write(10'h020, 8'h80);
    pulse_irq(8'h80);
    dack_set(1'b0);
    check_val("spur_vec", bus.dout, 8'h0F);
    check_val("spur_en", {7'd0, bus.dout_en}, 8'h01);
    dack_set(1'b1);
    io_read(10'h021, rd_m, rd_a);
    check_val("spur_pend", rd_m, 8'h80);
    io_read(10'h022, rd_m, rd_a);
    check_val("spur_isr", rd_m, 8'h00);
    io_write(10'h022, 8'h80);
    io_read(10'h021, rd_m, rd_a);
    check_val("swclr_pend", rd_m, 8'h00);
    io_write(10'h020, 8'h00);
    tick(2);
    check_val("swclr_int", {7'd0, bus.intr}, 8'h00);

    // Asynchronous reset in the middle of an ack
    pulse_irq(8'h50);
    dack_set(1'b0);
    check_val("ra_vec", bus.dout, 8'h0C);
    check_val("ra_en", {7'd0, bus.dout_en}, 8'h01);
    rst_n = 1'b0;
    #1;
    check_val("ra_en_clr", {7'd0, bus.dout_en}, 8'h00);
    check_val("ra_int_clr", {7'd0, bus.intr}, 8'h00);
    check_val("ra_dout_clr", bus.dout, 8'h00);
    tick(1);
    bus.dack_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    io_read(10'h021, rd_m, rd_a);
    check_val("ra_pend", rd_m, 8'h00);
    io_read(10'h022, rd_m, rd_a);
    check_val("ra_isr", rd_m, 8'h00);

    // AUTO_EOI instance: repeated channel 0 without EOI writes
    for (int k = 0; k < 2; k++) begin
      pulse_irq(8'h01);
      check_val($sformatf("ae_int%0d", k), {7'd0, bus_ae.intr}, 8'h01);
      dack_set(1'b0);
      check_val($sformatf("ae_vec%0d", k), bus_ae.dout, 8'h08);
      dack_set(1'b1);
      io_read(10'h022, rd_m, rd_a);
      check_val($sformatf("ae_isr%0d", k), rd_a, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/isa_vector_intc.md
Name: isa_vector_intc

Overview:
- Parametrised vectored interrupt controller for the iCE40 ISA host board. It replaces the fixed two-source (PIT, keyboard) DRQ2/DACK2 vector logic.
- Latches up to NUM_IRQ edge-triggered requests and applies a mask with fixed priority and in-service tracking. It raises INT to the CPU and drives the vector byte on the DACK (INTA) strobe.
- Provides I/O-mapped mask, pending, in-service and EOI registers for the ISA bus.

Parameters:
- NUM_IRQ, 8, number of request channels; legal range 1..8; channel 0 is highest priority.
- BASE_PORT, 10'h020, I/O base address; uses BASE_PORT+0..+2.
- VECTOR_BASE, 8'h08, vector driven for channel i is VECTOR_BASE+i (8-bit wrap).
- SPURIOUS_VEC, 8'h0F, vector driven when an ack finds nothing eligible.
- AUTO_EOI, 0, 1 = in-service bit never set (no EOI needed).

Ports:
- CLK  in  1  system clock (100 MHz).
- RESET_N  in  1  asynchronous active-low reset.
- IRQ_IN  in  NUM_IRQ  request lines, asynchronous, rising-edge triggered.
- ISA_A  in  10  ISA address bits [9:0].
- ISA_D_IN  in  8  ISA data bus, input side.
- ISA_IOW  in  1  ISA I/O write strobe, active low, asynchronous.
- ISA_IOR  in  1  ISA I/O read strobe, active low, asynchronous.
- ISA_DACK  in  1  interrupt-acknowledge strobe (DACK2/INTA), active low, asynchronous.
- INT  out  1  interrupt request to CPU (drives ISA_DRQ2).
- DOUT  out  8  data to drive on ISA_D.
- DOUT_EN  out  1  top drives ISA_D = DOUT when high.

Behaviour:
- Reset (async, RESET_N=0): mask=0 (all enabled); pending, ISR, synchronisers, INT, DOUT, DOUT_EN all 0.
- Input sync: every asynchronous input passes through a 2-flop synchroniser, then a history flop. Edges are detected as rise = (hist==0 && sync==1) and fall = the reverse.
- Pending: on an IRQ_IN[i] rise, pending[i] <= 1.
- INT latency: INT is high exactly 4 CLK edges after the first edge that samples IRQ_IN[i] high, provided the channel is eligible.
- Eligibility: channel i is eligible when pending[i] && !mask[i] && no ISR bit at index <= i is set.
- INT: registered; INT <= (any eligible) && !ack_busy.
- Ack state machine, states IDLE -> ACK -> IDLE:
  - IDLE, on DACK fall: pick the lowest-index eligible channel. DOUT <= VECTOR_BASE+i, DOUT_EN <= 1, pending[i] <= 0, ISR[i] <= !AUTO_EOI, INT <= 0, go to ACK.
  - IDLE, DACK fall with no eligible channel: DOUT <= SPURIOUS_VEC, DOUT_EN <= 1, no state bits change, go to ACK.
  - ACK, on DACK rise: DOUT_EN <= 0, go to IDLE. INT may reassert on the following cycle.
  - ack_busy = (state==ACK).
- Same-cycle collisions:
  - A rise on IRQ_IN[i] in the same cycle as the ack clears pending[i]: pending[i] ends at 1 (the new edge wins).
  - An EOI and an ack in the same cycle: the EOI applies first, then the ack selects.
- I/O write (IOW rise, address latched that cycle):
  - BASE_PORT+0: mask <= ISA_D_IN[NUM_IRQ-1:0].
  - BASE_PORT+1: non-specific EOI, clears the lowest-index set ISR bit; no effect if ISR==0.
  - BASE_PORT+2: pending &= ~ISA_D_IN (software clear).
  - Other addresses: ignored.
- I/O read (IOR fall): DOUT_EN <= 1. DOUT = mask for +0, pending for +1, ISR for +2, zero-extended to 8 bits. Other addresses leave DOUT_EN unchanged.
- IOR rise: DOUT_EN <= 0.
- Masked channels still latch pending; unmasking later raises INT.
- Bits above NUM_IRQ-1 read as 0 and ignore writes.

Test Plan:
- Reset, NUM_IRQ=8: pulse IRQ_IN[3] -> INT high exactly 4 cycles later. DACK low -> DOUT=8'h0B, DOUT_EN=1, INT=0. DACK high -> DOUT_EN=0. Read +2 -> 8'h08.
- Pulse IRQ_IN[5] and IRQ_IN[1] together -> first ack vector 8'h09, INT stays low (ISR[1] blocks 5). Write +1 -> ISR cleared, INT rises, second ack vector 8'h0D.
- Write mask 8'h04, pulse IRQ_IN[2] -> INT stays 0, read +1 -> 8'h04. Write mask 0 -> INT high.
- DACK pulse with nothing pending -> DOUT=8'h0F; pending and ISR unchanged.
- AUTO_EOI=1: two sequential IRQ_IN[0] pulses, each acked -> vectors 8'h08 both times; ISR reads 0 throughout.
- Assert RESET_N=0 mid-ack (DOUT_EN=1) -> DOUT_EN, INT, pending and ISR all 0 immediately, without waiting for a CLK edge.
